// File: rtl/front_panel_ctrl.sv
// Front panel control: synchronises and debounces the 25 panel switch codes, runs
// EXAMINE/DEPOSIT/RESET/STEP against the memory bus and drives the 36-bit LED vector.
module front_panel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RESET_CYCLES    = 8,
  parameter int MEM_TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [49:0] switches_status,  // switch code i at [2*i+1:2*i]
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic [9:0]  cpu_status,
  input  logic        cpu_wait,
  input  logic        cpu_hlda,
  output logic        cpu_stop,
  output logic        cpu_step,
  output logic        cpu_reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [35:0] leds_status
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int MAX_C = (MEM_TIMEOUT > RESET_CYCLES) ? MEM_TIMEOUT : RESET_CYCLES;
  localparam int CNT_W = $clog2(MAX_C) + 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_RST  = 3'd3,
    ST_STEP = 3'd4
  } state_t;

  // ON/OFF and STOP/RUN come out of reset in the ON + STOP position.
  function automatic logic [1:0] reset_code(input int idx);
    return ((idx == 16) || (idx == 17)) ? 2'd1 : 2'd0;
  endfunction

  logic [1:0]      sync1_r  [0:24];
  logic [1:0]      sync2_r  [0:24];
  logic [1:0]      cand_r   [0:24];
  logic [1:0]      acc_r    [0:24];
  logic [1:0]      prev_r   [0:24];
  logic [DB_W-1:0] db_cnt_r [0:24];

  state_t      state_r, state_n;
  logic [CNT_W-1:0] fsm_cnt_r, fsm_cnt_n;
  logic [15:0] panel_addr_r, panel_addr_n;
  logic [7:0]  panel_data_r, panel_data_n;
  logic [7:0]  wdata_r, wdata_n;
  logic        mem_req_r, mem_we_r, cpu_step_r, cpu_reset_r, cpu_stop_r;
  logic [35:0] leds_r, leds_n;

  logic        on_s, stop_s, cmd_ok_s;
  logic        rise_exam_s, rise_dep_s, rise_rst_s, rise_prot_s, rise_step_s;
  logic [15:0] sw_addr_s;
  logic [15:0] show_addr_s;
  logic [7:0]  show_data_s;

  // Two-flop synchroniser then per-switch debounce: a code is accepted after
  // DEBOUNCE_CYCLES consecutive equal synchronised samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 25; i++) begin
        sync1_r[i]  <= reset_code(i);
        sync2_r[i]  <= reset_code(i);
        cand_r[i]   <= reset_code(i);
        acc_r[i]    <= reset_code(i);
        prev_r[i]   <= reset_code(i);
        db_cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 25; i++) begin
        sync1_r[i] <= switches_status[2*i +: 2];
        sync2_r[i] <= sync1_r[i];
        prev_r[i]  <= acc_r[i];
        if (sync2_r[i] == acc_r[i]) begin
          db_cnt_r[i] <= '0;
        end else if ((db_cnt_r[i] != '0) && (sync2_r[i] == cand_r[i])) begin
          if (db_cnt_r[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            acc_r[i]    <= sync2_r[i];
            db_cnt_r[i] <= '0;
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
          end
        end else begin
          cand_r[i] <= sync2_r[i];
          if (DEBOUNCE_CYCLES == 1) begin
            acc_r[i] <= sync2_r[i];
          end else begin
            db_cnt_r[i] <= DB_W'(1);
          end
        end
      end
    end
  end

  // Decode accepted switch positions and 0 -> active command edges.
  always_comb begin
    sw_addr_s = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      sw_addr_s[15-i] = (acc_r[i] != 2'd0);
    end
    on_s        = (acc_r[16] == 2'd1);
    stop_s      = (acc_r[17] == 2'd1);
    cmd_ok_s    = on_s & stop_s;
    rise_exam_s = (prev_r[18] == 2'd0) && ((acc_r[18] == 2'd1) || (acc_r[18] == 2'd2));
    rise_dep_s  = (prev_r[19] == 2'd0) && ((acc_r[19] == 2'd1) || (acc_r[19] == 2'd2));
    rise_rst_s  = (prev_r[20] == 2'd0) && ((acc_r[20] == 2'd1) || (acc_r[20] == 2'd2));
    rise_prot_s = (prev_r[21] == 2'd0) && ((acc_r[21] == 2'd1) || (acc_r[21] == 2'd2));
    rise_step_s = (prev_r[22] == 2'd0) && (acc_r[22] == 2'd2);
  end

  // Panel FSM next state and datapath updates.
  always_comb begin
    state_n      = state_r;
    fsm_cnt_n    = fsm_cnt_r;
    panel_addr_n = panel_addr_r;
    panel_data_n = panel_data_r;
    wdata_n      = wdata_r;
    if (!on_s) begin
      state_n   = ST_IDLE;
      fsm_cnt_n = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          fsm_cnt_n = '0;
          if (!cmd_ok_s) begin
            state_n = ST_IDLE;
          end else if (rise_rst_s) begin
            state_n      = ST_RST;
            panel_addr_n = 16'h0000;
            panel_data_n = 8'h00;
          end else if (rise_exam_s) begin
            state_n = ST_RD;
            if (acc_r[18] == 2'd2) begin
              panel_addr_n = sw_addr_s;
            end else begin
              panel_addr_n = panel_addr_r + 16'd1;
            end
          end else if (rise_dep_s) begin
            state_n = ST_WR;
            wdata_n = sw_addr_s[7:0];
            if (acc_r[19] == 2'd1) begin
              panel_addr_n = panel_addr_r + 16'd1;
            end else begin
              panel_addr_n = panel_addr_r;
            end
          end else if (rise_prot_s) begin
            // PROTECT/UNPROTECT wins arbitration but has no action.
            state_n = ST_IDLE;
          end else if (rise_step_s) begin
            state_n = ST_STEP;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_RD: begin
          if (mem_ack) begin
            panel_data_n = mem_rdata;
            state_n      = ST_IDLE;
          end else if (fsm_cnt_r == CNT_W'(MEM_TIMEOUT - 1)) begin
            panel_data_n = 8'hFF;
            state_n      = ST_IDLE;
          end else begin
            fsm_cnt_n = fsm_cnt_r + CNT_W'(1);
          end
        end
        ST_WR: begin
          if (mem_ack) begin
            state_n   = ST_RD;
            fsm_cnt_n = '0;
          end else if (fsm_cnt_r == CNT_W'(MEM_TIMEOUT - 1)) begin
            panel_data_n = 8'hFF;
            state_n      = ST_IDLE;
          end else begin
            fsm_cnt_n = fsm_cnt_r + CNT_W'(1);
          end
        end
        ST_RST: begin
          if (fsm_cnt_r == CNT_W'(RESET_CYCLES - 1)) begin
            state_n = ST_IDLE;
          end else begin
            fsm_cnt_n = fsm_cnt_r + CNT_W'(1);
          end
        end
        ST_STEP: begin
          state_n = ST_IDLE;
        end
        default: begin
          state_n   = ST_IDLE;
          fsm_cnt_n = '0;
        end
      endcase
    end
  end

  // LED vector: addr/data fields reversed so LED 0 is A15 and LED 16 is D7.
  always_comb begin
    leds_n      = 36'h0;
    show_addr_s = cpu_stop_r ? panel_addr_r : cpu_addr;
    show_data_s = cpu_stop_r ? panel_data_r : cpu_data;
    if (on_s) begin
      for (int i = 0; i < 16; i++) begin
        leds_n[i] = show_addr_s[15-i];
      end
      for (int i = 0; i < 8; i++) begin
        leds_n[16+i] = show_data_s[7-i];
      end
      leds_n[33:24] = cpu_status;
      leds_n[34]    = cpu_wait;
      leds_n[35]    = cpu_hlda;
    end else begin
      leds_n = 36'h0;
    end
  end

  // FSM state, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      fsm_cnt_r    <= '0;
      panel_addr_r <= 16'h0000;
      panel_data_r <= 8'h00;
      wdata_r      <= 8'h00;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      cpu_step_r   <= 1'b0;
      cpu_reset_r  <= 1'b0;
      cpu_stop_r   <= 1'b1;
      leds_r       <= 36'h0;
    end else begin
      state_r      <= state_n;
      fsm_cnt_r    <= fsm_cnt_n;
      panel_addr_r <= panel_addr_n;
      panel_data_r <= panel_data_n;
      wdata_r      <= wdata_n;
      mem_req_r    <= (state_n == ST_RD) || (state_n == ST_WR);
      mem_we_r     <= (state_n == ST_WR);
      cpu_step_r   <= (state_n == ST_STEP);
      cpu_reset_r  <= (state_n == ST_RST);
      // Powered off keeps the CPU held as a safe state.
      cpu_stop_r   <= ~on_s | stop_s;
      leds_r       <= leds_n;
    end
  end

  assign cpu_stop    = cpu_stop_r;
  assign cpu_step    = cpu_step_r;
  assign cpu_reset   = cpu_reset_r;
  assign mem_req     = mem_req_r;
  assign mem_we      = mem_we_r;
  assign mem_addr    = panel_addr_r;
  assign mem_wdata   = wdata_r;
  assign leds_status = leds_r;

endmodule
